// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared types and constants for the FIFO read controller and its skid buffer.
package fifo_rd_ctrl_pkg;

    localparam int unsigned DATA_W = 32;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// Skid buffer: register array with wrapping pointers and occupancy counter.
// The head entry drives the stream data; valid is registered from occupancy.
module fifo_rd_skid
    import fifo_rd_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  word_t                    push_data_i,
    input  logic                     pop_i,
    output word_t                    head_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    word_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             valid_q;

    // Simultaneous push and pop leaves occupancy unchanged.
    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            valid_q <= (count_d != '0);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = valid_q;
    assign count_o = count_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Converts a fixed-latency (non-FWFT) FIFO read port into a valid/ready stream.
// Optional word counter enabled by defining FIFO_RD_CTRL_STAT_EN.
module fifo_rd_ctrl
    import fifo_rd_ctrl_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned BUF_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_re,
    input  logic              flush,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic [31:0]       stat_words
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + $clog2(READ_LATENCY + 1);

    state_e                  state_q;
    logic [READ_LATENCY-1:0] inflight_q;
    logic [READ_LATENCY-1:0] inflight_d;
    logic [CNT_W-1:0]        buf_count;
    logic                    pop;
    logic                    push;
    logic                    clr;
    logic [SUM_W-1:0]        pending_c;

    assign pop  = m_valid && m_ready;
    assign push = inflight_q[READ_LATENCY-1] && (state_q == ST_RUN);
    assign clr  = (state_q == ST_RUN) && flush;

    // Words owed to the buffer once this cycle's pop has left; must stay below depth.
    assign pending_c = SUM_W'(buf_count) + SUM_W'($countones(inflight_q)) - SUM_W'(pop);

    assign fifo_re = !rst && (state_q == ST_RUN) && !flush && !fifo_empty
                     && (pending_c < SUM_W'(BUF_DEPTH));

    assign inflight_d = (inflight_q << 1) | READ_LATENCY'(fifo_re);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            case (state_q)
                ST_RUN:   if (flush) state_q <= ST_FLUSH;
                ST_FLUSH: if (inflight_q == '0) state_q <= ST_RUN;
                default:  state_q <= ST_RUN;
            endcase
        end
    end

    assign busy = (state_q == ST_FLUSH);

    fifo_rd_skid #(
        .DEPTH (BUF_DEPTH)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (clr),
        .push_i      (push),
        .push_data_i (fifo_dout),
        .pop_i       (pop),
        .head_o      (m_data),
        .valid_o     (m_valid),
        .count_o     (buf_count)
    );

`ifdef FIFO_RD_CTRL_STAT_EN
    logic [31:0] stat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q <= '0;
        end else if (pop) begin
            stat_q <= stat_q + 32'd1;
        end
    end

    assign stat_words = stat_q;
`else
    assign stat_words = '0;
`endif

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter READ_LATENCY, default 2, SHALL be the cycles from fifo_re high to valid fifo_dout (FIFO with output register, non-FWFT).
REQ-002 Parameter BUF_DEPTH, default 4, SHALL be the skid-buffer entries; legal values are powers of two with BUF_DEPTH >= READ_LATENCY+1.
REQ-003 clk  input  1  sole clock; all logic on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 fifo_empty  input  1  FIFO empty flag.
REQ-006 fifo_dout  input  32  FIFO read data.
REQ-007 fifo_re  output  1  FIFO read enable.
REQ-008 flush  input  1  single-cycle request to discard all buffered and in-flight words.
REQ-009 m_data  output  32  stream data to the consumer.
REQ-010 m_valid  output  1  m_data holds a word.
REQ-011 m_ready  input  1  consumer accepts the word.
REQ-012 busy  output  1  high while in FLUSH.
REQ-013 stat_words  output  32  count of words accepted by the consumer.

Function
REQ-014 SHALL convert the FIFO's standard-latency read port into a valid/ready stream with zero-bubble throughput of 1 word/cycle.
REQ-015 Transfer SHALL occur on cycles where m_valid && m_ready; m_data/m_valid SHALL hold stable while m_valid && !m_ready.
REQ-016 m_valid SHALL not depend combinationally on m_ready; m_data SHALL be driven from the buffer head register.
REQ-017 In-flight reads SHALL be tracked by a READ_LATENCY-stage shift register of valid bits; a set final stage writes fifo_dout into the buffer that cycle.
REQ-018 fifo_re SHALL be asserted only when state is RUN, !fifo_empty, and (buffered + in_flight) < BUF_DEPTH, where buffered and in_flight are counted after the current cycle's pop.
REQ-019 Buffer SHALL never overflow; a returned word SHALL always find a free slot (guaranteed by REQ-018).
REQ-020 Simultaneous push and pop SHALL leave the occupancy unchanged; with occupancy 0, a returning word SHALL appear on m_data with m_valid in the following cycle.
REQ-021 Buffer read/write pointers SHALL be log2(BUF_DEPTH) bits and wrap modulo BUF_DEPTH; occupancy SHALL be log2(BUF_DEPTH)+1 bits.
REQ-022 Two-state FSM: RUN (normal) and FLUSH.
REQ-023 RUN->FLUSH on flush=1: the buffer SHALL be cleared at that edge, m_valid=0 from the next cycle, and no fifo_re is issued while in FLUSH.
REQ-024 In FLUSH, words returning from in-flight reads SHALL be discarded; FLUSH->RUN when the in-flight shift register is all zero.
REQ-025 flush received while already in FLUSH SHALL be ignored.
REQ-026 A transfer coincident with flush=1 SHALL count as accepted (stat_words increments) and the word is consumed.
REQ-027 busy SHALL be high exactly while state is FLUSH.

Reset
REQ-028 On rst: state=RUN, buffer empty, pointers 0, in-flight bits 0, fifo_re=0, m_valid=0, m_data=0, busy=0, stat_words=0.
REQ-029 rst asserted mid-operation SHALL drop all buffered and in-flight words without emitting them; the FIFO is reset by the same rst.

Configuration
REQ-030 With FIFO_RD_CTRL_STAT_EN defined, stat_words SHALL increment by 1 per transfer, wrapping 0xFFFFFFFF->0; without it, stat_words SHALL be constant 0 and the counter is not synthesized.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (RUN=0, FLUSH=1) and the 32-bit data-width constant.
REQ-032 The skid buffer SHALL be a sub-module, fifo_rd_skid (register array, pointers, occupancy); the FSM and in-flight tracking stay in fifo_rd_ctrl.

Verification
REQ-033 FIFO preloaded with 0x1..0x10, m_ready=1 -> first m_valid 3 cycles after first fifo_re, then 16 consecutive beats 0x1..0x10, no gaps.
REQ-034 FIFO holds 0x1..0x8, m_ready=0 -> exactly BUF_DEPTH=4 fifo_re pulses, m_data=0x1 held; then m_ready=1 -> 0x1..0x8 in order.
REQ-035 m_ready toggling 1,0,1,0 with FIFO of 0x1..0x20 -> no duplicates or losses, buffer occupancy never exceeds 4.
REQ-036 flush with 2 reads in flight and 2 words buffered -> m_valid=0 next cycle, busy high 2 cycles, in-flight words never emitted, next beat is the next FIFO word.
REQ-037 rst asserted with m_valid=1 -> all outputs 0 immediately; after release with FIFO refilled 0xA, 0xB -> stream emits 0xA, 0xB.
REQ-038 FIFO_RD_CTRL_STAT_EN defined, 100 transfers -> stat_words=100; undefined -> stat_words=0 throughout.
